// File: rtl/imem_arb.sv
// imem_arb: shares one single-port synchronous instruction memory between IF fetches and the program loader.
// Define IMEM_ARB_PERF_EN to build the saturating stall/load performance counters; otherwise both read 0.

module imem_arb #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 32,
  parameter int MAX_LOAD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              fetch_stall,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_inst,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_load_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } grant_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_LOAD_BURST);

  grant_t     state;
  grant_t     grant;
  logic [3:0] burst_cnt;

  // The loader wins contention until it has held the port for BURST_LIMIT
  // consecutive grants; then fetch gets exactly one cycle. ">=" also covers
  // a loader-only run that pushed the count past the limit.
  always_comb begin
    grant = IDLE;
    if (!reset_n) begin
      grant = IDLE;
    end else if (fetch_req && ld_req) begin
      if (state == LOAD && burst_cnt >= BURST_LIMIT) begin
        grant = FETCH;
      end else begin
        grant = LOAD;
      end
    end else if (fetch_req) begin
      grant = FETCH;
    end else if (ld_req) begin
      grant = LOAD;
    end
  end

  assign mem_we      = (grant == LOAD);
  assign ld_ack      = (grant == LOAD);
  assign mem_addr    = (grant == LOAD) ? ld_addr : fetch_addr;
  assign mem_wdata   = (grant == LOAD) ? ld_wdata : '0;
  assign fetch_stall = fetch_req && (grant != FETCH);
  assign fetch_inst  = fetch_valid ? mem_rdata : '0;

  // Burst count saturates at 15 so a long loader-only run cannot wrap and
  // starve a fetch that arrives afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      burst_cnt   <= 4'd0;
      fetch_valid <= 1'b0;
    end else begin
      state       <= grant;
      fetch_valid <= (grant == FETCH) && !flush;
      if (grant == LOAD) begin
        if (burst_cnt != 4'hF) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        burst_cnt <= 4'd0;
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] load_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'd0;
      load_cnt_q  <= 32'd0;
    end else begin
      if (fetch_stall && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ld_ack && load_cnt_q != 32'hFFFF_FFFF) begin
        load_cnt_q <= load_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_load_cnt  = load_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_load_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: table vectors, hand-written burst/reset sequences and randomized traffic for imem_arb,
// checked against a grant-history reference model and a shadow copy of instruction memory.

module tb_imem_arb;

  localparam int ADDR_W         = 64;
  localparam int DATA_W         = 32;
  localparam int MAX_LOAD_BURST = 4;

  logic              clk;
  logic              reset_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              flush;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_inst;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_load_cnt;

  imem_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_LOAD_BURST(MAX_LOAD_BURST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .flush(flush),
    .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid),
    .fetch_inst(fetch_inst),
    .ld_req(ld_req),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_ack(ld_ack),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_load_cnt(perf_load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] initWord(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Environment: 256-word synchronous memory, read data one cycle after the address.
  logic [31:0] env_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = initWord(i);
    forever begin
      @(posedge clk);
      if (mem_we) env_mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= env_mem[mem_addr[7:0]];
    end
  end

  // Reference model: previous grant, length of the current loader run,
  // pending fetch result and a shadow of the memory contents.
  logic [31:0] ref_mem [256];
  byte         m_prev;
  int          m_run;
  logic        m_pend_valid;
  logic [31:0] m_pend_data;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_load_cnt;

  byte         e_grant;
  logic        e_we;
  logic        e_ack;
  logic        e_stall;
  logic [63:0] e_addr;
  logic [31:0] e_wdata;
  logic        e_valid;
  logic [31:0] e_inst;

  task automatic modelReset();
    m_prev       = "I";
    m_run        = 0;
    m_pend_valid = 1'b0;
    m_pend_data  = 32'd0;
    m_stall_cnt  = 32'd0;
    m_load_cnt   = 32'd0;
  endtask

  task automatic modelEval();
    if (fetch_req && ld_req)
      e_grant = (m_prev == "L" && m_run >= MAX_LOAD_BURST) ? "F" : "L";
    else if (fetch_req)
      e_grant = "F";
    else if (ld_req)
      e_grant = "L";
    else
      e_grant = "I";
    e_we    = (e_grant == "L");
    e_ack   = (e_grant == "L");
    e_stall = fetch_req && (e_grant != "F");
    e_addr  = (e_grant == "L") ? ld_addr : fetch_addr;
    e_wdata = ld_wdata;
    e_valid = m_pend_valid;
    e_inst  = m_pend_valid ? m_pend_data : 32'd0;
  endtask

  task automatic modelCommit();
    if (e_grant == "F") begin
      m_pend_valid = !flush;
      m_pend_data  = ref_mem[fetch_addr[7:0]];
    end else begin
      m_pend_valid = 1'b0;
    end
    if (e_grant == "L") begin
      ref_mem[ld_addr[7:0]] = ld_wdata;
      m_run = (m_run < 15) ? m_run + 1 : 15;
    end else begin
      m_run = 0;
    end
`ifdef IMEM_ARB_PERF_EN
    if (e_stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 32'd1;
    if (e_ack && m_load_cnt != 32'hFFFF_FFFF) m_load_cnt = m_load_cnt + 32'd1;
`endif
    m_prev = e_grant;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input logic fr, input logic [63:0] fa, input logic fl,
                           input logic lr, input logic [63:0] la, input logic [31:0] lw);
    fetch_req  = fr;
    fetch_addr = fa;
    flush      = fl;
    ld_req     = lr;
    ld_addr    = la;
    ld_wdata   = lw;
  endtask

  task automatic applyStimulus(input logic fr, input logic [63:0] fa, input logic fl,
                               input logic lr, input logic [63:0] la, input logic [31:0] lw);
    @(negedge clk);
    setInputs(fr, fa, fl, lr, la, lw);
    #1;
    modelEval();
  endtask

  task automatic checkAgainstModel(input string tag);
    checkOutput({tag, ".mem_we"},      64'(mem_we),      64'(e_we));
    checkOutput({tag, ".ld_ack"},      64'(ld_ack),      64'(e_ack));
    checkOutput({tag, ".fetch_stall"}, 64'(fetch_stall), 64'(e_stall));
    checkOutput({tag, ".mem_addr"},    mem_addr,         e_addr);
    checkOutput({tag, ".fetch_valid"}, 64'(fetch_valid), 64'(e_valid));
    checkOutput({tag, ".fetch_inst"},  64'(fetch_inst),  64'(e_inst));
    if (e_we) checkOutput({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
    checkOutput({tag, ".perf_stall"},  64'(perf_stall_cnt), 64'(m_stall_cnt));
    checkOutput({tag, ".perf_load"},   64'(perf_load_cnt),  64'(m_load_cnt));
  endtask

  typedef struct {
    logic        fr;
    logic [63:0] fa;
    logic        fl;
    logic        lr;
    logic [63:0] la;
    logic [31:0] lw;
    logic        x_we;
    logic        x_ack;
    logic        x_stall;
    logic [63:0] x_addr;
    logic        x_valid;
    logic [31:0] x_inst;
  } vec_t;

  vec_t vecs [8];

  initial begin
    string pattern;

    // Hand-derived vectors starting from the reset state (memory idx = addr[7:0]).
    vecs[0] = '{1'b1, 64'h100, 1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h100, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 64'h104, 1'b0, 1'b1, 64'h40, 32'hDEADBEEF,  1'b1, 1'b1, 1'b0, 64'h40,  1'b1, 32'hC0DE_0000};
    vecs[2] = '{1'b1, 64'h40,  1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h40,  1'b0, 32'h0};
    vecs[3] = '{1'b1, 64'h44,  1'b1, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h44,  1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 64'h48,  1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h48,  1'b0, 32'h0};
    vecs[5] = '{1'b0, 64'h4C,  1'b1, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h4C,  1'b1, 32'hC0DE_0048};
    vecs[6] = '{1'b1, 64'h50,  1'b1, 1'b1, 64'h60, 32'h12345678,  1'b1, 1'b1, 1'b1, 64'h60,  1'b0, 32'h0};
    vecs[7] = '{1'b0, 64'h54,  1'b0, 1'b0, 64'h0,  32'h0,         1'b0, 1'b0, 1'b0, 64'h54,  1'b0, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
    modelReset();

    reset_n = 1'b0;
    setInputs(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.fetch_valid", 64'(fetch_valid), 64'd0);
    checkOutput("rst.mem_we",      64'(mem_we),      64'd0);
    checkOutput("rst.ld_ack",      64'(ld_ack),      64'd0);
    checkOutput("rst.fetch_stall", 64'(fetch_stall), 64'd0);
    checkOutput("rst.fetch_inst",  64'(fetch_inst),  64'd0);
    checkOutput("rst.perf_stall",  64'(perf_stall_cnt), 64'd0);
    checkOutput("rst.perf_load",   64'(perf_load_cnt),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].fr, vecs[i].fa, vecs[i].fl, vecs[i].lr, vecs[i].la, vecs[i].lw);
      checkOutput($sformatf("vec%0d.mem_we", i),      64'(mem_we),      64'(vecs[i].x_we));
      checkOutput($sformatf("vec%0d.ld_ack", i),      64'(ld_ack),      64'(vecs[i].x_ack));
      checkOutput($sformatf("vec%0d.fetch_stall", i), 64'(fetch_stall), 64'(vecs[i].x_stall));
      checkOutput($sformatf("vec%0d.mem_addr", i),    mem_addr,         vecs[i].x_addr);
      checkOutput($sformatf("vec%0d.fetch_valid", i), 64'(fetch_valid), 64'(vecs[i].x_valid));
      checkOutput($sformatf("vec%0d.fetch_inst", i),  64'(fetch_inst),  64'(vecs[i].x_inst));
      if (vecs[i].x_we)
        checkOutput($sformatf("vec%0d.mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].lw));
      modelCommit();
    end

    $display("[TB] loader burst under contention");
    applyStimulus(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 32'h0);
    checkOutput("burst.pre_fetch", 64'(mem_we), 64'd0);
    modelCommit();
    pattern = "LLLLFLLLLFLL";
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 64'(32'h10 + 4 * i), 1'b0, 1'b1, 64'(32'h80 + i), $urandom);
      checkOutput($sformatf("burst%0d.mem_we", i),      64'(mem_we),      64'(pattern[i] == "L"));
      checkOutput($sformatf("burst%0d.ld_ack", i),      64'(ld_ack),      64'(pattern[i] == "L"));
      checkOutput($sformatf("burst%0d.fetch_stall", i), 64'(fetch_stall), 64'(pattern[i] == "L"));
      modelCommit();
    end

    $display("[TB] reset during fetch");
    applyStimulus(1'b1, 64'h20, 1'b0, 1'b0, 64'h0, 32'h0);
    checkAgainstModel("prerst0");
    modelCommit();
    applyStimulus(1'b1, 64'h24, 1'b0, 1'b0, 64'h0, 32'h0);
    checkAgainstModel("prerst1");
    #2;
    reset_n = 1'b0;
    ld_req  = 1'b1;
    ld_addr = 64'h33;
    #1;
    checkOutput("midrst.fetch_valid", 64'(fetch_valid), 64'd0);
    checkOutput("midrst.fetch_inst",  64'(fetch_inst),  64'd0);
    checkOutput("midrst.mem_we",      64'(mem_we),      64'd0);
    checkOutput("midrst.ld_ack",      64'(ld_ack),      64'd0);
    checkOutput("midrst.mem_addr",    mem_addr,         64'h24);
    checkOutput("midrst.fetch_stall", 64'(fetch_stall), 64'd1);
    checkOutput("midrst.perf_stall",  64'(perf_stall_cnt), 64'd0);
    checkOutput("midrst.perf_load",   64'(perf_load_cnt),  64'd0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    setInputs(1'b1, 64'h28, 1'b0, 1'b0, 64'h0, 32'h0);
    #1;
    modelEval();
    checkOutput("release.fetch_valid", 64'(fetch_valid), 64'd0);
    checkAgainstModel("release");
    modelCommit();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 64'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)), 64'($urandom_range(0, 255)), $urandom);
      checkAgainstModel($sformatf("rnd%0d", i));
      modelCommit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
